cbfp_block_scaler: RTL and testbench



---
 rtl/cbfp_pkg.sv | 30 +++
 rtl/cbfp_shift_sat.sv | 55 +++++
 rtl/cbfp_block_scaler.sv | 203 ++++++++++++++++++++
 tb/tb_cbfp_block_scaler.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cbfp_pkg.sv
// rtl/cbfp_pkg.sv - shared constants and types for the CBFP block scaler
//
// Purpose: widths, lane/beat counts, sample/magnitude/exponent typedefs,
//          lane-array typedefs and the drain FSM state encoding.
// Ports:   none (package).
package cbfp_pkg;

   localparam int DATA_WIDTH = 23;
   localparam int MAG_WIDTH  = $clog2(DATA_WIDTH) + 1;
   localparam int OUT_WIDTH  = 11;
   localparam int LANES      = 16;
   localparam int BEATS      = 4;
   localparam int EXP_WIDTH  = 6;
   localparam int BEAT_W     = $clog2(BEATS);

   typedef logic signed [DATA_WIDTH-1:0] sample_t;
   typedef logic signed [OUT_WIDTH-1:0]  osample_t;
   typedef logic        [MAG_WIDTH-1:0]  mag_t;
   typedef logic signed [EXP_WIDTH-1:0]  exp_t;

   typedef sample_t  sample_arr_t  [LANES];
   typedef osample_t osample_arr_t [LANES];
   typedef mag_t     mag_arr_t     [LANES];

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_DRAIN = 1'b1
   } state_t;

endpackage

// File: rtl/cbfp_shift_sat.sv
// rtl/cbfp_shift_sat.sv - per-sample block-exponent shifter
//
// Purpose: scales one DATA_WIDTH sample to OUT_WIDTH by the block exponent.
//          shift > 0 : arithmetic right shift (floor); shift <= 0 : left shift.
//          With CBFP_ROUND_EN defined, right shifts round half up and the
//          result saturates to the OUT_WIDTH range.
// Ports:   din   - signed input sample
//          shift - signed block exponent
//          dout  - signed scaled sample (combinational)
module cbfp_shift_sat
   import cbfp_pkg::*;
(
   input  sample_t  din,
   input  exp_t     shift,
   output osample_t dout
);

   localparam int WW = DATA_WIDTH + 1;

   logic                 pos;
   logic [EXP_WIDTH-1:0] shamt;
   logic signed [WW-1:0] wide;
   logic signed [WW-1:0] res;

`ifdef CBFP_ROUND_EN
   localparam logic signed [WW-1:0] OMAX = WW'((1 << (OUT_WIDTH-1)) - 1);
   localparam logic signed [WW-1:0] OMIN = WW'(-(1 << (OUT_WIDTH-1)));
   logic signed [WW-1:0] rnd;
`endif

   always_comb begin
      pos   = !shift[EXP_WIDTH-1] && (shift != '0);
      shamt = pos ? shift : -shift;
      // One guard bit so the rounding add cannot overflow.
      wide  = {din[DATA_WIDTH-1], din};
`ifdef CBFP_ROUND_EN
      rnd = '0;
      if (pos) begin
         rnd = WW'(1) << (shamt - 1'b1);
      end
      res = pos ? ((wide + rnd) >>> shamt) : (wide <<< shamt);
      if (res > OMAX) begin
         res = OMAX;
      end else if (res < OMIN) begin
         res = OMIN;
      end
`else
      res = pos ? (wide >>> shamt) : (wide <<< shamt);
`endif
      // The exponent is chosen from the block maximum, so the result
      // always fits in OUT_WIDTH bits.
      dout = osample_t'(res);
   end

endmodule

// File: rtl/cbfp_block_scaler.sv
// rtl/cbfp_block_scaler.sv - CBFP block buffer, block exponent and scaler
//
// Purpose: collects BEATS beats of LANES complex samples into a ping-pong
//          store, tracks the block maximum magnitude, derives one shared
//          exponent per block and replays the block scaled to OUT_WIDTH.
//          Optional rounding/saturation: define CBFP_ROUND_EN.
// Ports:   clk, rst_n            - clock, async active-low reset
//          din_valid             - input beat qualifier
//          din_re/din_im         - LANES signed input samples
//          mag_re/mag_im         - leading-one index of |din_re|/|din_im|
//          dout_valid/dout_first - output beat qualifier / beat 0 of block
//          dout_re/dout_im       - LANES scaled samples
//          blk_exp               - block exponent, held until next beat 0
module cbfp_block_scaler
   import cbfp_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         din_valid,
   input  sample_arr_t  din_re,
   input  sample_arr_t  din_im,
   input  mag_arr_t     mag_re,
   input  mag_arr_t     mag_im,
   output logic         dout_valid,
   output logic         dout_first,
   output osample_arr_t dout_re,
   output osample_arr_t dout_im,
   output exp_t         blk_exp
);

   // Ping-pong store, no reset: contents are don't-care after reset.
   sample_t mem_re_q [2][BEATS][LANES];
   sample_t mem_im_q [2][BEATS][LANES];

   logic              wr_bank_q, wr_bank_d;
   logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
   mag_t              run_max_q, run_max_d;
   logic              pending_q, pending_d;
   exp_t              pend_exp_q, pend_exp_d;
   logic              pend_bank_q, pend_bank_d;

   state_t            state_q, state_d;
   logic [BEAT_W-1:0] rd_cnt_q, rd_cnt_d;
   logic              rd_bank_q, rd_bank_d;
   exp_t              cur_exp_q, cur_exp_d;

   logic              dout_valid_q, dout_valid_d;
   logic              dout_first_q, dout_first_d;
   osample_t          dout_re_q [LANES], dout_re_d [LANES];
   osample_t          dout_im_q [LANES], dout_im_d [LANES];
   exp_t              blk_exp_q, blk_exp_d;

   logic              blk_done;
   logic              pend_now;
   logic              take;
   mag_t              blk_max;
   exp_t              new_exp;

   sample_t           rd_re [LANES];
   sample_t           rd_im [LANES];
   osample_t          sh_re [LANES];
   osample_t          sh_im [LANES];

   // Fill side: running maximum, beat counter, block completion.
   always_comb begin
      blk_max = run_max_q;
      for (int i = 0; i < LANES; i++) begin
         if (mag_re[i] > blk_max) blk_max = mag_re[i];
         if (mag_im[i] > blk_max) blk_max = mag_im[i];
      end
      // need = max + 2 (magnitude bits plus sign); shift = need - OUT_WIDTH.
      new_exp  = exp_t'(blk_max) - exp_t'(OUT_WIDTH - 2);
      blk_done = din_valid && (beat_cnt_q == BEAT_W'(BEATS - 1));

      wr_bank_d  = wr_bank_q;
      beat_cnt_d = beat_cnt_q;
      run_max_d  = run_max_q;
      if (din_valid) begin
         if (blk_done) begin
            beat_cnt_d = '0;
            wr_bank_d  = ~wr_bank_q;
            run_max_d  = '0;
         end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
            run_max_d  = blk_max;
         end
      end

      // A block finishing this cycle is visible to the FSM right away so
      // back-to-back blocks drain without a bubble.
      pend_now    = pending_q || blk_done;
      pend_exp_d  = blk_done ? new_exp : pend_exp_q;
      pend_bank_d = blk_done ? wr_bank_q : pend_bank_q;
   end

   // Drain FSM.
   always_comb begin
      state_d   = state_q;
      rd_cnt_d  = rd_cnt_q;
      rd_bank_d = rd_bank_q;
      cur_exp_d = cur_exp_q;
      take      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pend_now) begin
               take     = 1'b1;
               state_d  = ST_DRAIN;
               rd_cnt_d = '0;
            end
         end
         ST_DRAIN: begin
            if (rd_cnt_q == BEAT_W'(BEATS - 1)) begin
               rd_cnt_d = '0;
               if (pend_now) begin
                  take = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               rd_cnt_d = rd_cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (take) begin
         rd_bank_d = pend_bank_d;
         cur_exp_d = pend_exp_d;
      end
      pending_d = pend_now && !take;
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      assign rd_re[g] = mem_re_q[rd_bank_q][rd_cnt_q][g];
      assign rd_im[g] = mem_im_q[rd_bank_q][rd_cnt_q][g];
      cbfp_shift_sat u_sh_re (.din(rd_re[g]), .shift(cur_exp_q), .dout(sh_re[g]));
      cbfp_shift_sat u_sh_im (.din(rd_im[g]), .shift(cur_exp_q), .dout(sh_im[g]));
   end

   // Output stage.
   always_comb begin
      dout_valid_d = (state_q == ST_DRAIN);
      dout_first_d = (state_q == ST_DRAIN) && (rd_cnt_q == '0);
      blk_exp_d    = dout_first_d ? cur_exp_q : blk_exp_q;
      for (int i = 0; i < LANES; i++) begin
         dout_re_d[i] = dout_valid_d ? sh_re[i] : '0;
         dout_im_d[i] = dout_valid_d ? sh_im[i] : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (din_valid) begin
         mem_re_q[wr_bank_q][beat_cnt_q] <= din_re;
         mem_im_q[wr_bank_q][beat_cnt_q] <= din_im;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_bank_q    <= 1'b0;
         beat_cnt_q   <= '0;
         run_max_q    <= '0;
         pending_q    <= 1'b0;
         pend_exp_q   <= '0;
         pend_bank_q  <= 1'b0;
         state_q      <= ST_IDLE;
         rd_cnt_q     <= '0;
         rd_bank_q    <= 1'b0;
         cur_exp_q    <= '0;
         dout_valid_q <= 1'b0;
         dout_first_q <= 1'b0;
         blk_exp_q    <= '0;
         for (int i = 0; i < LANES; i++) begin
            dout_re_q[i] <= '0;
            dout_im_q[i] <= '0;
         end
      end else begin
         wr_bank_q    <= wr_bank_d;
         beat_cnt_q   <= beat_cnt_d;
         run_max_q    <= run_max_d;
         pending_q    <= pending_d;
         pend_exp_q   <= pend_exp_d;
         pend_bank_q  <= pend_bank_d;
         state_q      <= state_d;
         rd_cnt_q     <= rd_cnt_d;
         rd_bank_q    <= rd_bank_d;
         cur_exp_q    <= cur_exp_d;
         dout_valid_q <= dout_valid_d;
         dout_first_q <= dout_first_d;
         blk_exp_q    <= blk_exp_d;
         for (int i = 0; i < LANES; i++) begin
            dout_re_q[i] <= dout_re_d[i];
            dout_im_q[i] <= dout_im_d[i];
         end
      end
   end

   assign dout_valid = dout_valid_q;
   assign dout_first = dout_first_q;
   assign dout_re    = dout_re_q;
   assign dout_im    = dout_im_q;
   assign blk_exp    = blk_exp_q;

endmodule

// File: tb/tb_cbfp_block_scaler.sv
// tb/tb_cbfp_block_scaler.sv - self-checking bench for cbfp_block_scaler
module tb_cbfp_block_scaler;
   import cbfp_pkg::*;

   localparam int PW = LANES * OUT_WIDTH;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         din_valid;
   sample_arr_t  din_re, din_im;
   mag_arr_t     mag_re, mag_im;
   logic         dout_valid, dout_first;
   osample_arr_t dout_re, dout_im;
   exp_t         blk_exp;

   cbfp_block_scaler dut (
      .clk(clk), .rst_n(rst_n), .din_valid(din_valid),
      .din_re(din_re), .din_im(din_im), .mag_re(mag_re), .mag_im(mag_im),
      .dout_valid(dout_valid), .dout_first(dout_first),
      .dout_re(dout_re), .dout_im(dout_im), .blk_exp(blk_exp)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_assert = 0;
   int n_fail   = 0;
   int n_out    = 0;

   // Expected output beats, in order.
   logic [PW-1:0] q_re[$], q_im[$];
   int            q_exp[$], q_cyc[$];
   bit            q_first[$];

   int blk_re [BEATS][LANES];
   int blk_im [BEATS][LANES];

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
      n_assert++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   function automatic int mag_of(input int x);
      int a, m;
      a = (x < 0) ? -x : x;
      m = 0;
      for (int i = 0; i < DATA_WIDTH; i++) if (((a >> i) & 1) == 1) m = i;
      return m;
   endfunction

   // Reference scaling from the arithmetic rules.
   function automatic int scale(input int x, input int e);
      int r;
      if (e > 0) begin
`ifdef CBFP_ROUND_EN
         r = (x + (1 << (e - 1))) >>> e;
         if (r > (1 << (OUT_WIDTH-1)) - 1) r = (1 << (OUT_WIDTH-1)) - 1;
         if (r < -(1 << (OUT_WIDTH-1))) r = -(1 << (OUT_WIDTH-1));
`else
         r = x >>> e;
`endif
      end else begin
         r = x * (1 << (-e));
      end
      return r;
   endfunction

   function automatic int rnd_sample(input int w);
      return int'($urandom_range(0, (1 << (w + 1)) - 1)) - (1 << w);
   endfunction

   task automatic fill_random();
      int w;
      w = $urandom_range(0, DATA_WIDTH - 1);
      for (int b = 0; b < BEATS; b++)
         for (int l = 0; l < LANES; l++) begin
            blk_re[b][l] = rnd_sample($urandom_range(0, w));
            blk_im[b][l] = rnd_sample($urandom_range(0, w));
         end
   endtask

   task automatic fill_const(input int v);
      for (int b = 0; b < BEATS; b++)
         for (int l = 0; l < LANES; l++) begin
            blk_re[b][l] = v;
            blk_im[b][l] = v;
         end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         din_valid = 1'b0;
      end
   endtask

   task automatic drive_beat(input int b);
      @(negedge clk);
      din_valid = 1'b1;
      for (int l = 0; l < LANES; l++) begin
         din_re[l] = sample_t'(blk_re[b][l]);
         din_im[l] = sample_t'(blk_im[b][l]);
         mag_re[l] = mag_t'(mag_of(blk_re[b][l]));
         mag_im[l] = mag_t'(mag_of(blk_im[b][l]));
      end
   endtask

   // Drives the current block and queues its expected output.
   task automatic drive_block(input bit gaps);
      int mx, e, c0;
      logic [PW-1:0] pr, pi;
      mx = 0;
      for (int b = 0; b < BEATS; b++)
         for (int l = 0; l < LANES; l++) begin
            if (mag_of(blk_re[b][l]) > mx) mx = mag_of(blk_re[b][l]);
            if (mag_of(blk_im[b][l]) > mx) mx = mag_of(blk_im[b][l]);
         end
      e = mx + 2 - OUT_WIDTH;
      for (int b = 0; b < BEATS; b++) begin
         if (gaps) idle($urandom_range(0, 2));
         drive_beat(b);
      end
      c0 = cyc + 2;
      for (int b = 0; b < BEATS; b++) begin
         for (int l = 0; l < LANES; l++) begin
            pr[l*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(scale(blk_re[b][l], e));
            pi[l*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(scale(blk_im[b][l], e));
         end
         q_re.push_back(pr);
         q_im.push_back(pi);
         q_exp.push_back(e);
         q_first.push_back(b == 0);
         q_cyc.push_back(c0 + b);
      end
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 100 && q_re.size() != 0; i++) @(negedge clk);
      check("drain_done", 256'(q_re.size()), 256'(0));
   endtask

   task automatic clear_model();
      q_re.delete(); q_im.delete(); q_exp.delete(); q_first.delete(); q_cyc.delete();
   endtask

   task automatic check_zero_out(input string tag);
      logic [PW-1:0] zr, zi;
      for (int l = 0; l < LANES; l++) begin
         zr[l*OUT_WIDTH +: OUT_WIDTH] = dout_re[l];
         zi[l*OUT_WIDTH +: OUT_WIDTH] = dout_im[l];
      end
      check({tag, "_valid"}, 256'(dout_valid), 256'(0));
      check({tag, "_first"}, 256'(dout_first), 256'(0));
      check({tag, "_re"}, 256'(zr), 256'(0));
      check({tag, "_im"}, 256'(zi), 256'(0));
      check({tag, "_exp"}, 256'(blk_exp), 256'(0));
   endtask

   // Output monitor: every valid beat must match the next queued beat.
   logic [PW-1:0] o_re, o_im;
   always @(negedge clk) begin
      if (rst_n && dout_valid) begin
         check("beat_expected", 256'(q_re.size() != 0), 256'(1));
         if (q_re.size() != 0) begin
            for (int l = 0; l < LANES; l++) begin
               o_re[l*OUT_WIDTH +: OUT_WIDTH] = dout_re[l];
               o_im[l*OUT_WIDTH +: OUT_WIDTH] = dout_im[l];
            end
            check("dout_re", 256'(o_re), 256'(q_re.pop_front()));
            check("dout_im", 256'(o_im), 256'(q_im.pop_front()));
            check("blk_exp", 256'(blk_exp), 256'(exp_t'(q_exp.pop_front())));
            check("dout_first", 256'(dout_first), 256'(q_first.pop_front()));
            check("beat_cycle", 256'(cyc), 256'(q_cyc.pop_front()));
            n_out++;
         end
      end
   end

   initial begin
      int n0;
      rst_n     = 1'b0;
      din_valid = 1'b0;
      for (int l = 0; l < LANES; l++) begin
         din_re[l] = '0; din_im[l] = '0; mag_re[l] = '0; mag_im[l] = '0;
      end
      repeat (3) @(negedge clk);
      check_zero_out("reset");
      rst_n = 1'b1;
      idle(2);

      // All 1024 -> exponent +1, outputs 512.
      fill_const(1024);
      drive_block(1'b0);
      idle(1);
      wait_drain();

      // Lane 3 at full-scale negative, others 4095 -> exponent 13.
      fill_const(4095);
      blk_re[1][3] = -4194304;
      drive_block(1'b0);
      idle(1);
      wait_drain();

      // All-zero block -> exponent -9, zeros.
      fill_const(0);
      drive_block(1'b0);
      idle(1);
      wait_drain();
      idle(3);

      // Max 40 with others 1 -> exponent -4.
      fill_const(1);
      blk_im[2][7] = 40;
      drive_block(1'b0);
      idle(1);
      wait_drain();

      // Three continuous random blocks, then one with gaps.
      n0 = n_out;
      for (int k = 0; k < 3; k++) begin
         fill_random();
         drive_block(1'b0);
      end
      fill_random();
      drive_block(1'b1);
      idle(1);
      wait_drain();
      check("cont_beats", 256'(n_out - n0), 256'(4 * BEATS));

      // Reset after two beats of a block.
      fill_random();
      drive_beat(0);
      drive_beat(1);
      idle(1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_zero_out("rst_fill");
      @(negedge clk);
      rst_n = 1'b1;
      n0 = n_out;
      fill_random();
      drive_block(1'b0);
      idle(1);
      wait_drain();
      check("post_rst_fill_beats", 256'(n_out - n0), 256'(BEATS));

      // Reset during a drain.
      fill_random();
      drive_block(1'b0);
      idle(2);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_zero_out("rst_drain");
      clear_model();
      @(negedge clk);
      rst_n = 1'b1;
      n0 = n_out;
      fill_random();
      drive_block(1'b0);
      idle(8);
      wait_drain();
      check("post_rst_drain_beats", 256'(n_out - n0), 256'(BEATS));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
